// File: rtl/line_sequencer_if.sv
// Line sequencer bus bundle: controller request, vertex-memory read port and
// line-drawer handshake. The master modport is the sequencer's view.
interface line_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    // Frame/scene controller side
    logic              start;
    logic [ADDR_W-1:0] list_base;
    logic [ADDR_W:0]   n_lines;
    logic              seq_busy;
    logic              frame_done;

    // Vertex memory read port
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    // Line drawer handshake
    logic              go;
    logic              busy;
    logic [7:0]        stax;
    logic [7:0]        stay;
    logic [7:0]        endx;
    logic [7:0]        endy;

    modport master (
        input  start, list_base, n_lines, mem_data, busy,
        output mem_addr, go, stax, stay, endx, endy, seq_busy, frame_done
    );

    modport slave (
        output start, list_base, n_lines, mem_data, busy,
        input  mem_addr, go, stax, stay, endx, endy, seq_busy, frame_done
    );
endinterface

// File: rtl/line_sequencer.sv
// Line sequencer: walks a list of segments in a synchronous vertex memory and
// hands each one to the line drawer with a go/busy handshake. Coordinates are
// registered and held from GO until the drawer drops busy.
module line_sequencer #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    line_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_GO,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       seg_q, seg_d;
    logic              go_q, go_d;
    logic              seq_busy_q, seq_busy_d;
    logic              done_q, done_d;

    // idx is one bit wider than the address so a full 2^ADDR_W list terminates
    assign idx_inc = idx_q + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state and next-output logic; every output is computed one state ahead
    // so that the registered value is valid during the state it belongs to.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        seg_d      = seg_q;
        go_d       = 1'b0;
        seq_busy_d = seq_busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d     = bus.list_base;
                    count_d    = bus.n_lines;
                    idx_d      = '0;
                    addr_d     = bus.list_base;
                    seq_busy_d = 1'b1;
                    if (bus.n_lines == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            // mem_addr already holds base + idx; the memory samples it this cycle
            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                seg_d   = bus.mem_data;
                go_d    = 1'b1;
                state_d = S_GO;
            end

            S_GO: begin
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (bus.busy) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (!bus.busy) begin
                    idx_d  = idx_inc;
                    addr_d = base_q + idx_inc[ADDR_W-1:0];
                    if (idx_inc == count_q) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FINISH: begin
                seq_busy_d = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                seq_busy_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any list in progress at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            seg_q      <= '0;
            go_q       <= 1'b0;
            seq_busy_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            seg_q      <= seg_d;
            go_q       <= go_d;
            seq_busy_q <= seq_busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.go         = go_q;
    assign bus.stax       = seg_q[31:24];
    assign bus.stay       = seg_q[23:16];
    assign bus.endx       = seg_q[15:8];
    assign bus.endy       = seg_q[7:0];
    assign bus.seq_busy   = seq_busy_q;
    assign bus.frame_done = done_q;

endmodule
